// File: rtl/s2mm_pkg.sv
// Shared definitions for the S2MM command arbiter: FSM encoding, command field
// widths and the DataMover S2MM command builder.
package s2mm_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int CMD_W  = 72;
  localparam int ADDR_W = 32;
  localparam int BTT_W  = 23;

  localparam logic CMD_EOF  = 1'b1;
  localparam logic CMD_TYPE = 1'b1;  // incrementing-address transfer

  function automatic logic [CMD_W-1:0] build_s2mm_cmd(input logic [ADDR_W-1:0] addr,
                                                      input logic [BTT_W-1:0]  btt);
    return {8'h00, addr, 1'b0, CMD_EOF, 6'h00, CMD_TYPE, btt};
  endfunction

endpackage

// File: rtl/s2mm_ring_addr.sv
// Per-requester DDR ring-buffer pointer: advances one packet per completed
// transfer and wraps after DEPTH packets; pack_num counts 1..DEPTH.
module s2mm_ring_addr
  import s2mm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE  = 32'h3e00_0000,
  parameter logic [ADDR_W-1:0] STEP  = 32'd320,
  parameter int                DEPTH = 10
) (
  input  logic              clk_ps,
  input  logic              rst_n,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       pack_num
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE + STEP * ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_N   = 32'(DEPTH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= BASE;
      pack_num <= 32'd0;
    end else if (advance) begin
      addr     <= (addr == LAST_ADDR) ? BASE : addr + STEP;
      pack_num <= (pack_num == DEPTH_N) ? 32'd1 : pack_num + 32'd1;
    end
  end

endmodule

// File: rtl/s2mm_cmd_arbiter.sv
// Round-robin sharing of one DataMover S2MM channel between two packet producers.
// Optional status-error counter enabled by defining S2MM_STS_EN.
module s2mm_cmd_arbiter
  import s2mm_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR0 = 32'h3e00_0000,
  parameter logic [ADDR_W-1:0] START_ADDR1 = 32'h3f00_0000,
  parameter logic [BTT_W-1:0]  BTT         = 23'd320,
  parameter int                DATA_PACK   = 10
) (
  input  logic             clk_ps,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       grant,
  input  logic [63:0]      s0_tdata,
  input  logic             s0_tvalid,
  input  logic             s0_tlast,
  output logic             s0_tready,
  input  logic [63:0]      s1_tdata,
  input  logic             s1_tvalid,
  input  logic             s1_tlast,
  output logic             s1_tready,
  output logic             m_cmd_tvalid,
  input  logic             m_cmd_tready,
  output logic [CMD_W-1:0] m_cmd_tdata,
  output logic [63:0]      m_tdata,
  output logic [7:0]       m_tkeep,
  output logic             m_tvalid,
  output logic             m_tlast,
  input  logic             m_tready,
  output logic [31:0]      pack_num0,
  output logic [31:0]      pack_num1,
  output logic             len_err
`ifdef S2MM_STS_EN
  ,
  input  logic             s_sts_tvalid,
  input  logic [7:0]       s_sts_tdata,
  output logic             s_sts_tready,
  output logic [15:0]      err_cnt
`endif
);

  localparam int                BEATS     = int'(BTT >> 3);
  localparam int                CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  logic [1:0]        state;
  logic              sel;
  logic              last_grant;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] addr0, addr1;
  logic              sel_tvalid, sel_tlast;
  logic [63:0]       sel_tdata;
  logic              next_sel, in_data, at_last, beat_acc, pkt_done;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    sel_tdata  = s0_tdata;
    sel_tvalid = s0_tvalid;
    sel_tlast  = s0_tlast;
    if (sel) begin
      sel_tdata  = s1_tdata;
      sel_tvalid = s1_tvalid;
      sel_tlast  = s1_tlast;
    end
  end

  // Tie-break favours the requester that was not served last.
  assign next_sel = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign in_data  = (state == ST_DATA);
  assign at_last  = (beat_cnt == LAST_BEAT);
  assign beat_acc = m_tvalid & m_tready;
  assign pkt_done = beat_acc & at_last;

  assign grant        = (state == ST_IDLE) ? 2'b00 : {sel, ~sel};
  assign m_cmd_tvalid = (state == ST_CMD);
  assign m_cmd_tdata  = build_s2mm_cmd(sel ? addr1 : addr0, BTT);
  assign m_tdata      = sel_tdata;
  assign m_tkeep      = 8'hff;
  assign m_tvalid     = in_data & sel_tvalid;
  assign m_tlast      = at_last & m_tvalid;
  assign s0_tready    = in_data & ~sel & m_tready;
  assign s1_tready    = in_data &  sel & m_tready;

  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
      len_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid != 2'b00) begin
            sel   <= next_sel;
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (m_cmd_tready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (beat_acc) begin
            // The beat count, not the producer's tlast, defines packet end.
            if (sel_tlast != at_last) len_err <= 1'b1;
            if (at_last) begin
              beat_cnt   <= '0;
              last_grant <= sel;
              state      <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  s2mm_ring_addr #(
    .BASE  (START_ADDR0),
    .STEP  (ADDR_W'(BTT)),
    .DEPTH (DATA_PACK)
  ) u_ring0 (
    .clk_ps   (clk_ps),
    .rst_n    (rst_n),
    .advance  (pkt_done & ~sel),
    .addr     (addr0),
    .pack_num (pack_num0)
  );

  s2mm_ring_addr #(
    .BASE  (START_ADDR1),
    .STEP  (ADDR_W'(BTT)),
    .DEPTH (DATA_PACK)
  ) u_ring1 (
    .clk_ps   (clk_ps),
    .rst_n    (rst_n),
    .advance  (pkt_done & sel),
    .addr     (addr1),
    .pack_num (pack_num1)
  );

`ifdef S2MM_STS_EN
  assign s_sts_tready = 1'b1;

  // Status bits 6:4 flag DMA internal, slave and decode errors.
  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 16'd0;
    end else if (s_sts_tvalid && (|s_sts_tdata[6:4]) && (err_cnt != 16'hffff)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_s2mm_cmd_arbiter.sv
// Randomized scoreboard bench for s2mm_cmd_arbiter: producers, ready drivers,
// a packet-level arbitration/ring model and an independent output monitor.
module tb_s2mm_cmd_arbiter;

  localparam int NBEAT  = 40;
  localparam int BUDGET = 20000;

  typedef struct packed {
    logic [31:0] salt;
    logic        bad;
  } pkt_t;

  typedef struct packed {
    logic [71:0] cmd;
    logic        req;
    logic [31:0] pnum;
  } cmd_exp_t;

  logic        clk_ps = 1'b0;
  logic        rst_n;
  logic        rv [2];
  logic [1:0]  req_valid;
  wire  [1:0]  grant;
  logic [63:0] sd [2];
  logic        sv [2];
  logic        sl [2];
  wire  [1:0]  srdy;
  wire         m_cmd_tvalid;
  logic        m_cmd_tready;
  wire  [71:0] m_cmd_tdata;
  wire  [63:0] m_tdata;
  wire  [7:0]  m_tkeep;
  wire         m_tvalid, m_tlast;
  logic        m_tready;
  wire  [31:0] pack_num0, pack_num1;
  wire         len_err;

  assign req_valid = {rv[1], rv[0]};

  s2mm_cmd_arbiter dut (
    .clk_ps       (clk_ps),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .grant        (grant),
    .s0_tdata     (sd[0]),
    .s0_tvalid    (sv[0]),
    .s0_tlast     (sl[0]),
    .s0_tready    (srdy[0]),
    .s1_tdata     (sd[1]),
    .s1_tvalid    (sv[1]),
    .s1_tlast     (sl[1]),
    .s1_tready    (srdy[1]),
    .m_cmd_tvalid (m_cmd_tvalid),
    .m_cmd_tready (m_cmd_tready),
    .m_cmd_tdata  (m_cmd_tdata),
    .m_tdata      (m_tdata),
    .m_tkeep      (m_tkeep),
    .m_tvalid     (m_tvalid),
    .m_tlast      (m_tlast),
    .m_tready     (m_tready),
    .pack_num0    (pack_num0),
    .pack_num1    (pack_num1),
    .len_err      (len_err)
  );

  always #5 clk_ps = ~clk_ps;

  int total = 0;
  int bad   = 0;

  pkt_t     q0 [$];
  pkt_t     q1 [$];
  cmd_exp_t cmd_q [$];
  logic [64:0] beat_q [$];

  bit   abort = 1'b0;
  bit   fast  = 1'b1;
  int   beats_seen = 0;
  bit   last_g;
  int   mk [2];
  logic exp_len_err;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_word(input int id, input int beat, input logic [31:0] salt);
    logic [63:0] x;
    x = {salt, 8'(id), 8'(beat), 16'h5a5a};
    return x * 64'h9e37_79b9_7f4a_7c15;
  endfunction

  function automatic logic [31:0] ring_base(input int id);
    return (id == 0) ? 32'h3e00_0000 : 32'h3f00_0000;
  endfunction

  // Packets written so far -> the pack_num value the ring should report.
  function automatic logic [31:0] exp_pnum(input int k);
    return (k == 0) ? 32'd0 : 32'(((k - 1) % 10) + 1);
  endfunction

  function automatic bit has_pkt(input int id);
    return (id == 0) ? (q0.size() != 0) : (q1.size() != 0);
  endfunction

  function automatic pkt_t front_pkt(input int id);
    return (id == 0) ? q0[0] : q1[0];
  endfunction

  // Producer: offers one packet at a time with random valid gaps.
  task automatic producer(input int id);
    bit   acc;
    int   bi = 0;
    pkt_t p;
    pkt_t dummy;
    forever begin
      @(negedge clk_ps);
      acc = sv[id] && srdy[id];
      @(posedge clk_ps);
      #1;
      if (abort) begin
        sv[id] = 1'b0; sl[id] = 1'b0; rv[id] = 1'b0; bi = 0;
        continue;
      end
      if (acc) begin
        bi++;
        if (bi == NBEAT) begin
          bi = 0;
          if (id == 0) dummy = q0.pop_front(); else dummy = q1.pop_front();
        end
      end
      if (has_pkt(id)) begin
        p = front_pkt(id);
        rv[id] = 1'b1;
        if (!sv[id] || acc) sv[id] = ($urandom_range(0, 3) != 0);
        sd[id] = beat_word(id, bi, p.salt);
        sl[id] = (bi == (p.bad ? NBEAT - 2 : NBEAT - 1));
      end else begin
        rv[id] = 1'b0; sv[id] = 1'b0; sl[id] = 1'b0;
      end
    end
  endtask

  initial producer(0);
  initial producer(1);

  initial begin
    m_cmd_tready = 1'b0;
    m_tready     = 1'b0;
    forever begin
      @(posedge clk_ps);
      #1;
      if (fast) begin
        m_cmd_tready = 1'b1;
        m_tready     = 1'b1;
      end else begin
        m_cmd_tready = ($urandom_range(0, 5) == 0);
        m_tready     = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a handshake.
  initial begin
    bit          cmd_wait = 1'b0;
    logic [71:0] held_cmd = '0;
    bit          pend = 1'b0;
    logic        pend_req = 1'b0;
    logic [31:0] pend_pn = '0;
    cmd_exp_t    cur = '0;
    cmd_exp_t    e;
    logic [64:0] b;
    forever begin
      @(negedge clk_ps);
      if (!rst_n) begin
        cmd_wait = 1'b0;
        pend     = 1'b0;
        continue;
      end
      if (pend) begin
        pend = 1'b0;
        check("pack_num_after_pkt", pend_req ? pack_num1 : pack_num0, pend_pn);
      end
      if (grant == 2'b01) check("s1_tready_idle", srdy[1], 1'b0);
      if (grant == 2'b10) check("s0_tready_idle", srdy[0], 1'b0);
      if (cmd_wait) begin
        check("cmd_valid_hold", m_cmd_tvalid, 1'b1);
        check("cmd_data_hold", m_cmd_tdata, held_cmd);
      end
      cmd_wait = m_cmd_tvalid && !m_cmd_tready;
      held_cmd = m_cmd_tdata;
      if (m_cmd_tvalid && m_cmd_tready) begin
        check("cmd_expected", cmd_q.size() != 0, 1'b1);
        if (cmd_q.size() != 0) begin
          e = cmd_q.pop_front();
          check("cmd_tdata", m_cmd_tdata, e.cmd);
          check("grant", grant, e.req ? 2'b10 : 2'b01);
          cur = e;
        end
      end
      if (m_tvalid && m_tready) begin
        beats_seen++;
        check("beat_expected", beat_q.size() != 0, 1'b1);
        if (beat_q.size() != 0) begin
          b = beat_q.pop_front();
          check("beat_last_data", {m_tlast, m_tdata}, b);
          check("tkeep", m_tkeep, 8'hff);
          if (b[64]) begin
            pend     = 1'b1;
            pend_req = cur.req;
            pend_pn  = cur.pnum;
          end
        end
      end
    end
  end

  task automatic finish_tb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", grant, 2'b00);
    check("rst_cmd_tvalid", m_cmd_tvalid, 1'b0);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_s_tready", srdy, 2'b00);
    check("rst_pack_num0", pack_num0, 32'd0);
    check("rst_pack_num1", pack_num1, 32'd0);
    check("rst_len_err", len_err, 1'b0);
  endtask

  task automatic model_reset();
    last_g      = 1'b1;
    mk[0]       = 0;
    mk[1]       = 0;
    exp_len_err = 1'b0;
  endtask

  // Loads n0/n1 packets at once; predicts grant order and ring state per packet.
  task automatic load_phase(input int n0, input int n1, input bit bad0);
    pkt_t     p0 [$];
    pkt_t     p1 [$];
    pkt_t     p;
    cmd_exp_t e;
    int       i0 = 0, i1 = 0;
    int       pick;
    logic [31:0] addr;
    @(posedge clk_ps);
    #2;
    for (int i = 0; i < n0; i++) p0.push_back('{salt: $urandom, bad: bad0 && (i == 0)});
    for (int i = 0; i < n1; i++) p1.push_back('{salt: $urandom, bad: 1'b0});
    while (i0 < n0 || i1 < n1) begin
      if (i0 < n0 && i1 < n1) pick = last_g ? 0 : 1;
      else pick = (i0 < n0) ? 0 : 1;
      if (pick == 0) begin p = p0[i0]; i0++; end
      else begin p = p1[i1]; i1++; end
      addr   = ring_base(pick) + 32'((mk[pick] % 10) * 320);
      mk[pick]++;
      e.cmd  = {8'h00, addr, 1'b0, 1'b1, 6'h00, 1'b1, 23'd320};
      e.req  = 1'(pick);
      e.pnum = exp_pnum(mk[pick]);
      cmd_q.push_back(e);
      for (int b = 0; b < NBEAT; b++)
        beat_q.push_back({b == NBEAT - 1, beat_word(pick, b, p.salt)});
      if (p.bad) exp_len_err = 1'b1;
      last_g = 1'(pick);
    end
    foreach (p0[i]) q0.push_back(p0[i]);
    foreach (p1[i]) q1.push_back(p1[i]);
    rv[0] = (n0 != 0);
    rv[1] = (n1 != 0);
  endtask

  task automatic run_phase(input int n0, input int n1, input bit bad0);
    int n = 0;
    load_phase(n0, n1, bad0);
    while ((cmd_q.size() != 0 || beat_q.size() != 0 || rv[0] || rv[1]) && n < BUDGET) begin
      @(posedge clk_ps);
      n++;
    end
    check("phase_done_in_budget", n < BUDGET, 1'b1);
    if (n >= BUDGET) finish_tb();
    repeat (3) @(posedge clk_ps);
    #1;
    check("pack_num0_end", pack_num0, exp_pnum(mk[0]));
    check("pack_num1_end", pack_num1, exp_pnum(mk[1]));
    check("len_err_end", len_err, exp_len_err);
    check("grant_idle_end", grant, 2'b00);
  endtask

  initial begin
    int n;
    int start;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; sv[i] = 1'b0; sl[i] = 1'b0; sd[i] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk_ps);
    #1;
    check_reset_outputs();
    @(negedge clk_ps);
    rst_n = 1'b1;

    // Both requesting from reset: 0,1,0,1 at full throughput.
    run_phase(2, 2, 1'b0);
    fast = 1'b0;
    run_phase(1, 0, 1'b0);
    // Long single-requester run crosses the ring wrap.
    run_phase(11, 0, 1'b0);
    // Early tlast on requester 0.
    run_phase(1, 1, 1'b1);
    for (int r = 0; r < 3; r++) run_phase($urandom_range(0, 3), $urandom_range(1, 3), 1'b0);

    // Reset in the middle of a packet.
    load_phase(1, 0, 1'b0);
    start = beats_seen;
    n = 0;
    while (beats_seen - start < 20 && n < BUDGET) begin
      @(posedge clk_ps);
      n++;
    end
    check("mid_packet_reached", n < BUDGET, 1'b1);
    @(posedge clk_ps);
    #3;
    rst_n = 1'b0;
    abort = 1'b1;
    #1;
    check_reset_outputs();
    cmd_q.delete();
    beat_q.delete();
    q0.delete();
    q1.delete();
    model_reset();
    repeat (3) @(posedge clk_ps);
    @(negedge clk_ps);
    rst_n = 1'b1;
    abort = 1'b0;

    run_phase(0, 1, 1'b0);
    run_phase(2, 1, 1'b0);
    finish_tb();
  end

endmodule
